// File: rtl/p_acc_serial.sv
`default_nettype none
// ============================================================================
// Module   : p_acc_serial
// Purpose  : Streaming frame accumulator. Sums IN elements that arrive one per
//            valid/ready handshake in a widened register. Saturates the full
//            sum once, at the end of the frame, and presents one result per
//            frame on a valid/ready output.
// Ports    : clk, reset_ (async, active low)
//            in_valid / in_ready / in_data  - element stream, CONF format
//            out_valid / out_ready / out    - saturated frame sum, CONF format
//            udf / ovf / rounded            - clamp flags, held with out
// Option   : P_ACC_SERIAL_LAST_EN adds the in_last frame delimiter input and
//            the out_cnt output (number of elements summed).
// Revision : 1.0 - initial release
// ============================================================================

`ifndef Enable
`define Enable 1'b1
`endif
`ifndef Disable
`define Disable 1'b0
`endif

package p_acc_serial_pkg;
    typedef enum logic [0:0] {INT = 1'b0, FXP = 1'b1} dtype_t;

    typedef struct packed {
        dtype_t dtype;
        logic   sign;
        int     prec;
        int     frac;
    } dconf_t;
endpackage

module p_acc_serial #(
    parameter int                      IN   = 5,
    parameter p_acc_serial_pkg::dconf_t CONF = '{dtype: p_acc_serial_pkg::INT,
                                                sign:  `Enable,
                                                prec:  8,
                                                frac:  0}
) (
    input  logic                        clk,
    input  logic                        reset_,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [CONF.prec-1:0]        in_data,
`ifdef P_ACC_SERIAL_LAST_EN
    input  logic                        in_last,
    output logic [$clog2(IN+1)-1:0]     out_cnt,
`endif
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [CONF.prec-1:0]        out,
    output logic                        udf,
    output logic                        ovf,
    output logic                        rounded
);

    localparam int  P      = CONF.prec;
    // Wide enough for IN worst-case elements, so no intermediate overflow.
    localparam int  ACCW   = P + $clog2(IN) + 1;
    localparam int  CW     = $clog2(IN + 1);
    localparam bit  c_sign = CONF.sign;

    localparam logic [ACCW-1:0] c_smax = {{(ACCW-P+1){1'b0}}, {(P-1){1'b1}}};
    localparam logic [ACCW-1:0] c_smin = {{(ACCW-P+1){1'b1}}, {(P-1){1'b0}}};
    localparam logic [ACCW-1:0] c_umax = {{(ACCW-P){1'b0}}, {P{1'b1}}};
    localparam logic [CW-1:0]   c_last = CW'(IN - 1);

    typedef enum logic [0:0] {S_ACC = 1'b0, S_OUT = 1'b1} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ACCW-1:0]   r_acc;
    logic [CW-1:0]     r_cnt;
    logic [P-1:0]      r_out;
    logic              r_udf;
    logic              r_ovf;
    logic              r_rounded;
    logic [CW-1:0]     r_out_cnt;

    logic              w_accept;
    logic              w_last;
    logic [ACCW-1:0]   w_ext;
    logic [ACCW-1:0]   w_sum;
    logic [P-1:0]      w_sat;
    logic              w_udf;
    logic              w_ovf;

    // Element widened to the accumulator width in the configured signedness.
    assign w_ext = c_sign ? {{(ACCW-P){in_data[P-1]}}, in_data}
                          : {{(ACCW-P){1'b0}}, in_data};
    assign w_sum = r_acc + w_ext;

`ifdef P_ACC_SERIAL_LAST_EN
    assign w_last = (r_cnt == c_last) | in_last;
`else
    assign w_last = (r_cnt == c_last);
`endif

    // Clamp the exact sum into the output format. FXP is treated on raw bits.
    always_comb begin
        w_sat = w_sum[P-1:0];
        w_udf = 1'b0;
        w_ovf = 1'b0;
        if (c_sign) begin
            if ($signed(w_sum) > $signed(c_smax)) begin
                w_sat = c_smax[P-1:0];
                w_ovf = 1'b1;
            end else if ($signed(w_sum) < $signed(c_smin)) begin
                w_sat = c_smin[P-1:0];
                w_udf = 1'b1;
            end
        end else if (w_sum > c_umax) begin
            w_sat = c_umax[P-1:0];
            w_ovf = 1'b1;
        end
    end

    // Next state and handshake outputs. in_ready stays low through the whole
    // OUT state, so the next frame starts at earliest one cycle after the
    // output handshake.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_ACC: begin
                in_ready = 1'b1;
                w_accept = in_valid;
                if (in_valid && w_last) begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_ACC;
                end
            end
            default: w_state_next = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_state   <= S_ACC;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_out     <= '0;
            r_udf     <= 1'b0;
            r_ovf     <= 1'b0;
            r_rounded <= 1'b0;
            r_out_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                if (w_last) begin
                    // Frame complete: capture the result and clear the
                    // accumulator now so the next frame starts from zero.
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_out     <= w_sat;
                    r_udf     <= w_udf;
                    r_ovf     <= w_ovf;
                    r_rounded <= w_udf | w_ovf;
                    r_out_cnt <= r_cnt + CW'(1);
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + CW'(1);
                end
            end
        end
    end

    assign out     = r_out;
    assign udf     = r_udf;
    assign ovf     = r_ovf;
    assign rounded = r_rounded;

`ifdef P_ACC_SERIAL_LAST_EN
    assign out_cnt = r_out_cnt;
`else
    // Element count is only exported with the delimiter option.
    logic w_unused_cnt;
    assign w_unused_cnt = ^r_out_cnt;
`endif

endmodule
`default_nettype wire

// File: doc/p_acc_serial.md
Name: p_acc_serial

Overview:
Streaming counterpart of the combinational vector accumulator p_acc. It accepts IN elements one per handshake on a valid/ready input and sums them in a widened internal register. It saturates once, at the end of the frame, and presents one result per frame on a valid/ready output. It sits after the serialized multiplier path of a perceptron neuron, where the products arrive over time rather than as one IN-wide vector.

Parameters:
IN, 5, elements per frame (>=2)
CONF, dconf_t'{dtype:INT, sign:`Enable, prec:8, frac:0}, data format of inputs and output (dtype INT/FXP, sign, prec, frac)
ACCW, CONF.prec+$clog2(IN)+1, internal accumulator width (derived, not overridden)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous active-low reset
in_valid  in  1  in_data is valid
in_ready  out  1  block accepts in_data this cycle
in_data  in  CONF.prec  element, CONF format
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out  out  CONF.prec  saturated frame sum, CONF format
udf  out  1  result clamped to format minimum
ovf  out  1  result clamped to format maximum
rounded  out  1  result differs from the exact sum (= udf|ovf)

Behaviour:
- Reset (async, reset_=0): state=ACC, acc=0, cnt=0, out_valid=0, out=0, udf=0, ovf=0, rounded=0, in_ready=1 after release.
- FSM states: ACC, OUT.
- ACC state:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: acc += sign-extended (zero-extended if CONF.sign=`Disable) in_data; cnt++.
  - When the accepted element is the IN-th (cnt==IN-1): go to OUT next cycle and register the saturated acc into out/udf/ovf/rounded; cnt=0.
- Latency: the result is valid the cycle after the last element is accepted.
- Saturation, applied once on the full ACCW sum:
  - Signed range [-2^(prec-1), 2^(prec-1)-1]; unsigned range [0, 2^prec-1].
  - Above max -> out=max, ovf=1. Below min -> out=min, udf=1.
  - FXP uses the same rule on raw bits; frac is unchanged because addition is exact within a format.
- OUT state:
  - in_ready=0; out_valid=1; out and flags held stable.
  - On out_ready: go to ACC, out_valid=0, acc=0.
  - in_ready is not asserted in the same cycle as the out handshake; the first element of the next frame is accepted at the earliest 1 cycle after the handshake.
- Intermediate overflow cannot occur: ACCW covers IN worst-case elements.
- in_valid while in_ready=0 is ignored; the upstream holds its data.
- Reset mid-frame discards the partial sum and counter; no output is produced.
- Flags are only meaningful while out_valid=1. They hold their last value until the next result is registered.

Optional Feature:
Macro P_ACC_SERIAL_LAST_EN.
- Defined:
  - Adds input in_last (1 bit) as a frame delimiter.
  - A frame ends on an accepted element with in_last=1, or on the IN-th element, whichever comes first.
  - An in_last on element k<IN produces the sum of k elements, with the same latency and saturation as a full frame.
  - Adds output out_cnt ($clog2(IN+1) bits), the number of elements summed, registered with out.
- Undefined: no in_last and no out_cnt; frames are always exactly IN elements.

Test Plan:
(INT, signed, prec 8, IN=5 unless noted)
1. Feed 0,1,2,3,4 with in_valid held high and out_ready=1 -> out_valid 1 cycle after the 5th accept; out=10; udf=ovf=rounded=0.
2. Feed 100,100,0,0,0 -> out=127, ovf=1, rounded=1, udf=0.
3. Feed -100,-100,-100,0,0 -> out=-128 (8'h80), udf=1, rounded=1.
4. Feed 127,127,-128,-128,1 -> out=-1, no flags; proves end-of-frame saturation only.
5. Hold out_ready=0 for 4 cycles after a result:
   - out, flags and out_valid stay stable; in_ready=0; in_valid pulses are not accepted.
   - Release out_ready -> handshake; next frame 1,1,1,1,1 gives out=5.
6. Accept 3 elements, assert reset_=0 for 1 cycle, then feed 2,2,2,2,2 -> out=10 with no stale partial sum. With P_ACC_SERIAL_LAST_EN, feed 7,8 with in_last on 8 -> out=15, out_cnt=2.
